cmd_mem_loader: RTL

Host-side load sequencer for the per-core command memory banks. Accepts a stream of MEM_WIDTH-bit host words, packs MEM_TO_CMD of them into one CMD_WIDTH command, and issues one write per command to sequential command addresses through the bank write port (cmd_write / cmd_write_addr / cmd_write_enable). Holds the attached processor core in reset while a load session is active, so fetch never sees a partially written program.

---
 rtl/cmd_mem_loader.sv | 107 ++++++++++
 1 files changed

// File: rtl/cmd_mem_loader.sv
// cmd_mem_loader: packs MEM_TO_CMD host words per command and writes them to sequential command addresses, holding the core in reset meanwhile
// Ports:
//   clk, reset (async, active-low)
//   load_start/load_base_addr/load_len : session request, sampled in IDLE only
//   load_abort                         : drop the session from any state
//   word_in/word_valid/word_ready      : host word stream (transfer on valid && ready)
//   cmd_write/cmd_write_addr/cmd_write_enable : command bank write port
//   proc_hold, busy, done              : core reset hold, session active, completion pulse
//   load_checksum                      : XOR of accepted words, present with CMD_LOAD_CHECKSUM_EN
module cmd_mem_loader #(
  parameter int CMD_ADDR_WIDTH = 8,
  parameter int MEM_WIDTH = 32,
  parameter int MEM_TO_CMD = 4,
  parameter int CMD_WIDTH = 128
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_start,
  input  logic [CMD_ADDR_WIDTH-1:0] load_base_addr,
  input  logic [CMD_ADDR_WIDTH:0]   load_len,
  input  logic                      load_abort,
  input  logic [MEM_WIDTH-1:0]      word_in,
  input  logic                      word_valid,
  output logic                      word_ready,
  output logic [CMD_WIDTH-1:0]      cmd_write,
  output logic [CMD_ADDR_WIDTH-1:0] cmd_write_addr,
  output logic                      cmd_write_enable,
  output logic                      proc_hold,
  output logic                      busy,
  output logic                      done
`ifdef CMD_LOAD_CHECKSUM_EN
  ,
  output logic [MEM_WIDTH-1:0]      load_checksum
`endif
);
  localparam int IW = MEM_TO_CMD > 1 ? $clog2(MEM_TO_CMD) : 1;
  localparam logic [1:0] IDLE = 2'd0, FILL = 2'd1, WRITE = 2'd2, DONE = 2'd3;
  logic [1:0] state, nxt;
  logic [IW-1:0] idx;
  logic [CMD_ADDR_WIDTH-1:0] addr;
  logic [CMD_ADDR_WIDTH:0] count, target, cnt_nxt;
  logic [CMD_WIDTH-1:0] pack, pack_nxt;
  logic start_ok, xfer, last;
  assign start_ok = state == IDLE && load_start && !load_abort;
  assign xfer = state == FILL && word_valid && word_ready && !load_abort;
  assign last = xfer && idx == IW'(MEM_TO_CMD - 1);
  assign cnt_nxt = count + 1'b1;
  // pack_nxt is the staging buffer with the incoming word dropped into slice idx;
  // cmd_write only takes it once the command is complete so the bank port never shows partial data
  always_comb begin
    pack_nxt = pack;
    for (int i = 0; i < MEM_TO_CMD; i++)
      if (idx == IW'(i)) pack_nxt[i*MEM_WIDTH +: MEM_WIDTH] = word_in;
  end
  always_comb
    nxt = load_abort    ? IDLE
        : state == IDLE  ? (start_ok ? (load_len == '0 ? DONE : FILL) : IDLE)
        : state == FILL  ? (last ? WRITE : FILL)
        : state == WRITE ? (cnt_nxt == target ? DONE : FILL)
        : IDLE;
  // outputs are decoded from the next state so they stay registered yet line up with the state they describe
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      idx <= '0;
      addr <= '0;
      count <= '0;
      target <= '0;
      pack <= '0;
      word_ready <= 1'b0;
      cmd_write <= '0;
      cmd_write_addr <= '0;
      cmd_write_enable <= 1'b0;
      proc_hold <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      word_ready <= nxt == FILL;
      cmd_write_enable <= nxt == WRITE;
      proc_hold <= nxt != IDLE;
      busy <= nxt != IDLE;
      done <= nxt == DONE;
      if (start_ok) begin
        addr <= load_base_addr;
        target <= load_len;
        count <= '0;
      end
      if (start_ok || load_abort) idx <= '0;
      else if (xfer) idx <= last ? '0 : idx + 1'b1;
      if (xfer) pack <= pack_nxt;
      if (last) begin
        cmd_write <= pack_nxt;
        cmd_write_addr <= addr;
      end
      if (state == WRITE && !load_abort) begin
        count <= cnt_nxt;
        addr <= addr + 1'b1;
      end
    end
`ifdef CMD_LOAD_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) load_checksum <= '0;
    else if (start_ok) load_checksum <= '0;
    else if (xfer) load_checksum <= load_checksum ^ word_in;
`endif
endmodule
